pulse_param_fifo: RTL

- Downstream neighbour of the per-element pulse parameter register stage.
- Captures the full pulse parameter set (env_word, phase, freq, amp, cfg) on every command strobe and queues it in a small FIFO.
- Presents the queue to the signal-generator element with a valid/ready handshake, so a short burst of pulses issued back-to-back by the processor is not lost while the element is busy.
- Reports occupancy and a sticky overflow error.

---
 rtl/pulse_pkg.sv | 18 +
 rtl/pulse_param_fifo_ptr_ctrl.sv | 85 ++++++++
 rtl/pulse_param_fifo.sv | 80 ++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared widths and storage entry type for the pulse parameter FIFO.
//   ENV_WORD_WIDTH/PHASE_WIDTH/FREQ_WIDTH/AMP_WIDTH/CFG_WIDTH : field widths
//   pulse_params_t : one queued parameter set {env_word, phase, freq, amp, cfg}
package pulse_pkg;
  localparam int ENV_WORD_WIDTH = 24;
  localparam int PHASE_WIDTH    = 17;
  localparam int FREQ_WIDTH     = 9;
  localparam int AMP_WIDTH      = 16;
  localparam int CFG_WIDTH      = 4;

  typedef struct packed {
    logic [ENV_WORD_WIDTH-1:0] env_word;
    logic [PHASE_WIDTH-1:0]    phase;
    logic [FREQ_WIDTH-1:0]     freq;
    logic [AMP_WIDTH-1:0]      amp;
    logic [CFG_WIDTH-1:0]      cfg;
  } pulse_params_t;
endpackage

// File: rtl/pulse_param_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer/occupancy control for pulse_param_fifo.
//   clk, reset        : clock, synchronous active-high reset
//   strobe_i          : push request
//   ready_i           : consumer accepts head
//   clear_err_i       : clears sticky overflow (and drop counter)
//   push_o            : qualified write enable for the storage array
//   wr_ptr_o/rd_ptr_o : storage write / head read index
//   count_o, valid_o, full_o, overflow_o : status
//   drop_cnt_o        : saturating drop counter (PULSE_PARAM_FIFO_DROP_CNT_EN only)
module fifo_ptr_ctrl #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe_i,
  input  logic                 ready_i,
  input  logic                 clear_err_i,
  output logic                 push_o,
  output logic [PTR_W-1:0]     wr_ptr_o,
  output logic [PTR_W-1:0]     rd_ptr_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 valid_o,
  output logic                 full_o,
  output logic                 overflow_o
`ifdef PULSE_PARAM_FIFO_DROP_CNT_EN
  , output logic [15:0]        drop_cnt_o
`endif
);
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, push, drop;

  always_comb begin
    valid_o  = (count_q != '0);
    full_o   = (count_q == CNT_WIDTH'(DEPTH));
    pop      = valid_o & ready_i;
    // a pop frees a slot this cycle, so a full FIFO can still accept
    push     = strobe_i & (~full_o | pop);
    drop     = strobe_i & full_o & ~pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // a new drop wins over clear
    ovf_d    = drop | (ovf_q & ~clear_err_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign push_o     = push;
  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

`ifdef PULSE_PARAM_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_err_i)                    drop_cnt_d = {15'd0, drop};
    else if (drop && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: rtl/pulse_param_fifo.sv
// pulse_param_fifo: queues pulse parameter sets between the parameter register
// stage and the signal-generator element (first-word-fall-through, valid/ready).
//   clk, reset            : clock, synchronous active-high reset
//   *_in, cstrobe_in      : parameter set and push strobe
//   out_ready             : element accepts head entry
//   clear_err             : clears sticky overflow
//   out_valid, *_out      : head entry
//   count, full, overflow : occupancy and sticky drop flag
//   drop_count            : present only with PULSE_PARAM_FIFO_DROP_CNT_EN
module pulse_param_fifo
  import pulse_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ENV_WORD_WIDTH-1:0] env_word_in,
  input  logic [PHASE_WIDTH-1:0]    phase_in,
  input  logic [FREQ_WIDTH-1:0]     freq_in,
  input  logic [AMP_WIDTH-1:0]      amp_in,
  input  logic [CFG_WIDTH-1:0]      cfg_in,
  input  logic                      cstrobe_in,
  input  logic                      out_ready,
  input  logic                      clear_err,
  output logic                      out_valid,
  output logic [ENV_WORD_WIDTH-1:0] env_word_out,
  output logic [PHASE_WIDTH-1:0]    phase_out,
  output logic [FREQ_WIDTH-1:0]     freq_out,
  output logic [AMP_WIDTH-1:0]      amp_out,
  output logic [CFG_WIDTH-1:0]      cfg_out,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      full,
  output logic                      overflow
`ifdef PULSE_PARAM_FIFO_DROP_CNT_EN
  , output logic [15:0]             drop_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  pulse_params_t        mem [DEPTH];
  pulse_params_t        wr_ent, head;
  logic                 push;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .PTR_W(PTR_W)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .strobe_i   (cstrobe_in),
    .ready_i    (out_ready),
    .clear_err_i(clear_err),
    .push_o     (push),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count),
    .valid_o    (out_valid),
    .full_o     (full),
    .overflow_o (overflow)
`ifdef PULSE_PARAM_FIFO_DROP_CNT_EN
    , .drop_cnt_o(drop_count)
`endif
  );

  assign wr_ent = '{env_word: env_word_in, phase: phase_in, freq: freq_in,
                    amp: amp_in, cfg: cfg_in};

  // Only entry 0 is cleared: rd_ptr resets to 0, so outputs read zero after
  // reset while the remaining entries stay plain enable flops.
  always_ff @(posedge clk) begin
    if (reset)     mem[0]      <= '0;
    else if (push) mem[wr_ptr] <= wr_ent;
  end

  assign head         = mem[rd_ptr];
  assign env_word_out = head.env_word;
  assign phase_out    = head.phase;
  assign freq_out     = head.freq;
  assign amp_out      = head.amp;
  assign cfg_out      = head.cfg;
endmodule
